interval_timer: RTL and testbench
=================================

# interval_timer

Programmable interval timer that the traffic-light FSM drives. It holds the three light-phase durations (base, extended, yellow), divides `clk` down to a one-second tick, and counts the selected duration in seconds. When the count finishes it returns a single-cycle `expired` pulse. It sits beside the FSM and consumes its `start_timer` / `interval_address` outputs. It takes the synchronised program strobe and parameter bus from the input conditioning stage.

## Interface
- `CLK_DIV`, default 50_000_000: clock cycles per one-second tick; legal range ≥1.
- `VAL_W`, default 4: width of interval values in seconds.
- `clk`, in, 1: system clock. The block uses one clock.
- `sys_reset`, in, 1: reset, asynchronous and active-low.
- `start_timer`, in, 1: one-cycle request to load and start the interval chosen by `interval_address`.
- `interval_address`, in, 2: interval to start. 00 = base, 01 = extended, 10 = yellow, 11 = base.
- `prg_sync_in`, in, 1: one-cycle write strobe. Already synchronised.
- `time_parameter_selector`, in, 2: register to write. Encoding matches `interval_address`; 11 = write ignored.
- `time_value`, in, VAL_W: value to write, in seconds.
- `expired`, out, 1: one-cycle pulse when the interval completes.
- `busy`, out, 1: high while a count is running.
- `one_hz_enable`, out, 1: prescaler tick, one cycle wide. Exported for blinking the walk lamp.
- `remaining`, out, VAL_W: seconds left in the current count; 0 when idle.

## Operation
- Interval registers reset to their defaults: base = 6, extended = 3, yellow = 2.
- Write: on `prg_sync_in`=1, the selected register takes `time_value`. If `time_value`=0, the register takes its default value.
- A write also aborts any running count: next state is IDLE, `remaining` is 0, and no `expired` pulse is produced.
- States:
  - IDLE: `busy`=0. On `start_timer`, go to COUNT.
  - COUNT: `busy`=1. On each tick: if `remaining`=1, set `remaining` to 0 and go to DONE; otherwise decrement `remaining`.
  - DONE: `expired`=1 for exactly this cycle. Next state is IDLE.
- Start from any state: `remaining` loads the selected register, the prescaler clears to 0, and the next state is COUNT.
  - A start during COUNT re-triggers the count. No pulse is produced for the abandoned count.
  - A start during DONE still shows `expired` that cycle, then counts the new interval.
- Priority when events coincide in the same cycle: `prg_sync_in` beats `start_timer`. The start is dropped and the write takes effect.
- Prescaler:
  - Free-running counter over 0..CLK_DIV−1. Tick is asserted when the count equals CLK_DIV−1.
  - Cleared by start and by reset.
  - With CLK_DIV=1 the tick is asserted every cycle.
- Arithmetic: `remaining` never wraps. A tick with `remaining`=0 outside COUNT has no effect.

## Timing
- Reset values: state IDLE; `expired` = `busy` = `one_hz_enable` = 0; `remaining` = 0; prescaler = 0; interval registers at their defaults.
- Reset mid-count forces all of the above immediately, asynchronously.
- All outputs are registered state or decode of registered state; no input reaches an output combinationally.
- `expired` is a Moore output of DONE.
- `start_timer` sampled at edge t with value N: `busy`=1 after edge t, and `expired` is high in the cycle after edge t + N·CLK_DIV. Latency is exactly N·CLK_DIV cycles.
- A write sampled at edge t is visible to a start sampled at edge t+1.
- `one_hz_enable` runs continuously, including in IDLE.

## Structure
- Shared package `traffic_pkg` holds:
  - interval address encodings `IV_BASE`, `IV_EXT`, `IV_YEL`;
  - default durations `DEF_BASE`=6, `DEF_EXT`=3, `DEF_YEL`=2;
  - timer state enum `{T_IDLE, T_COUNT, T_DONE}`.
- One sub-module, `one_hz_prescaler`:
  - parameter `CLK_DIV`;
  - ports `clk`, `sys_reset`, `clear`, `tick`;
  - counter width is $clog2(CLK_DIV), minimum 1.
- The interval register file and the FSM stay in `interval_timer`.

## Test plan
All scenarios use CLK_DIV=4.
- Release reset, then start with `interval_address`=00: `remaining` steps 6→0 every 4 cycles, and `expired` pulses for 1 cycle exactly 24 cycles after the start edge.
- Write selector 01 with value 9, then start with address 01: `expired` pulses 36 cycles after start. Base remains 6.
- Write selector 10 with value 0, then start with address 10: yellow holds default 2, and `expired` pulses at 8 cycles.
- Start base, then assert `prg_sync_in` at `remaining`=4: `busy` drops the next cycle, `remaining` becomes 0, and no `expired` pulse occurs for 30 cycles.
- Start base, then re-start with address 10 at `remaining`=3: `remaining` becomes 2, there is a single `expired` pulse 8 cycles after the re-start, and nothing for the first count.
- Assert `start_timer` and `prg_sync_in` together: write applied, `busy` stays 0. Assert `sys_reset`=0 mid-count: all outputs go to 0 immediately, and programmed values revert to their defaults.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared encodings and defaults for the traffic-light timer.
// Interval addresses, default durations and timer states.
package traffic_pkg;

  localparam logic [1:0] IV_BASE = 2'b00;
  localparam logic [1:0] IV_EXT  = 2'b01;
  localparam logic [1:0] IV_YEL  = 2'b10;

  localparam int DEF_BASE = 6;
  localparam int DEF_EXT  = 3;
  localparam int DEF_YEL  = 2;

  typedef enum logic [1:0] {
    T_IDLE,
    T_COUNT,
    T_DONE
  } timer_state_e;

endpackage

// File: rtl/interval_timer_if.sv
// Control/status bundle between the light FSM and the timer.
// master = FSM/conditioning side, slave = interval_timer.
interface interval_timer_if #(
  parameter int VAL_W = 4
);

  logic             start_timer;
  logic [1:0]       interval_address;
  logic             prg_sync_in;
  logic [1:0]       time_parameter_selector;
  logic [VAL_W-1:0] time_value;
  logic             expired;
  logic             busy;
  logic             one_hz_enable;
  logic [VAL_W-1:0] remaining;

  modport master (
    output start_timer,
    output interval_address,
    output prg_sync_in,
    output time_parameter_selector,
    output time_value,
    input  expired,
    input  busy,
    input  one_hz_enable,
    input  remaining
  );

  modport slave (
    input  start_timer,
    input  interval_address,
    input  prg_sync_in,
    input  time_parameter_selector,
    input  time_value,
    output expired,
    output busy,
    output one_hz_enable,
    output remaining
  );

endinterface

// File: rtl/one_hz_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_DIV cycles.
// tick is registered and lines up with count == CLK_DIV-1.
module one_hz_prescaler #(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic sys_reset,
  input  logic clear,
  output logic tick
);

  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);
  localparam logic ZERO_LAST = (LAST == '0);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_nxt;

  assign cnt_nxt = (cnt == LAST) ? '0 : cnt + W'(1);

  // free-running count; tick flop mirrors the next count
  always_ff @(posedge clk or negedge sys_reset) begin
    if (!sys_reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      tick <= ZERO_LAST;
    end else begin
      cnt  <= cnt_nxt;
      tick <= (cnt_nxt == LAST);
    end
  end

endmodule

// File: rtl/interval_timer.sv
// Programmable interval timer for the traffic-light FSM.
// Holds base/extended/yellow durations and counts in seconds.
module interval_timer
  import traffic_pkg::*;
#(
  parameter int CLK_DIV = 50_000_000,
  parameter int VAL_W   = 4
) (
  input logic           clk,
  input logic           sys_reset,
  interval_timer_if.slave bus
);

  localparam logic [VAL_W-1:0] DEF_B = VAL_W'(DEF_BASE);
  localparam logic [VAL_W-1:0] DEF_E = VAL_W'(DEF_EXT);
  localparam logic [VAL_W-1:0] DEF_Y = VAL_W'(DEF_YEL);

  timer_state_e     state;
  logic [VAL_W-1:0] base_q;
  logic [VAL_W-1:0] ext_q;
  logic [VAL_W-1:0] yel_q;
  logic [VAL_W-1:0] rem_q;
  logic [VAL_W-1:0] sel_val;
  logic             busy_q;
  logic             exp_q;
  logic             tick;
  logic             start;
  logic             wr_zero;

  // a coinciding write drops the start, so it must not clear either
  assign start   = bus.start_timer & ~bus.prg_sync_in;
  assign wr_zero = (bus.time_value == '0);

  one_hz_prescaler #(
    .CLK_DIV(CLK_DIV)
  ) u_presc (
    .clk      (clk),
    .sys_reset(sys_reset),
    .clear    (start),
    .tick     (tick)
  );

  // interval register file; zero writes restore the default
  always_ff @(posedge clk or negedge sys_reset) begin
    if (!sys_reset) begin
      base_q <= DEF_B;
      ext_q  <= DEF_E;
      yel_q  <= DEF_Y;
    end else if (bus.prg_sync_in) begin
      unique case (1'b1)
        (bus.time_parameter_selector == IV_BASE):
          base_q <= wr_zero ? DEF_B : bus.time_value;
        (bus.time_parameter_selector == IV_EXT):
          ext_q <= wr_zero ? DEF_E : bus.time_value;
        (bus.time_parameter_selector == IV_YEL):
          yel_q <= wr_zero ? DEF_Y : bus.time_value;
        default: ;
      endcase
    end
  end

  // duration selected by the start address; 11 aliases base
  always_comb begin
    sel_val = base_q;
    unique case (1'b1)
      (bus.interval_address == IV_EXT): sel_val = ext_q;
      (bus.interval_address == IV_YEL): sel_val = yel_q;
      default: ;
    endcase
  end

  // timer FSM with registered busy/expired; write > start > count
  always_ff @(posedge clk or negedge sys_reset) begin
    if (!sys_reset) begin
      state  <= T_IDLE;
      rem_q  <= '0;
      busy_q <= 1'b0;
      exp_q  <= 1'b0;
    end else if (bus.prg_sync_in) begin
      state  <= T_IDLE;
      rem_q  <= '0;
      busy_q <= 1'b0;
      exp_q  <= 1'b0;
    end else if (bus.start_timer) begin
      state  <= T_COUNT;
      rem_q  <= sel_val;
      busy_q <= 1'b1;
      exp_q  <= 1'b0;
    end else begin
      unique case (state)
        T_COUNT: begin
          if (tick) begin
            if (rem_q <= VAL_W'(1)) begin
              state  <= T_DONE;
              rem_q  <= '0;
              busy_q <= 1'b0;
              exp_q  <= 1'b1;
            end else begin
              rem_q <= rem_q - VAL_W'(1);
            end
          end
        end
        T_DONE: begin
          state <= T_IDLE;
          exp_q <= 1'b0;
        end
        default: begin
          state  <= T_IDLE;
          busy_q <= 1'b0;
          exp_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.expired       = exp_q;
  assign bus.busy          = busy_q;
  assign bus.remaining     = rem_q;
  assign bus.one_hz_enable = tick;

endmodule

// File: tb/tb_interval_timer.sv
// Directed bench for interval_timer at CLK_DIV=4.
// Expected values are hand-derived from the timer behaviour.
module tb_interval_timer;

  logic clk = 1'b0;
  logic sys_reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  interval_timer_if #(.VAL_W(4)) bus ();

  interval_timer #(
    .CLK_DIV(4),
    .VAL_W  (4)
  ) dut (
    .clk      (clk),
    .sys_reset(sys_reset),
    .bus      (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [1:0] a);
    bus.start_timer = 1'b1;
    bus.interval_address = a;
    step();
    bus.start_timer = 1'b0;
  endtask

  task automatic wr(input logic [1:0] s, input logic [3:0] v);
    bus.prg_sync_in = 1'b1;
    bus.time_parameter_selector = s;
    bus.time_value = v;
    step();
    bus.prg_sync_in = 1'b0;
  endtask

  task automatic run(input int max, output int first, output int np);
    first = -1;
    np = 0;
    for (int k = 1; k <= max; k++) begin
      step();
      if (bus.expired === 1'b1) begin
        np++;
        if (first < 0) first = k;
      end
    end
  endtask

  task automatic wait_rem(input int val, input int max,
                          output int cyc, output int np);
    cyc = -1;
    np = 0;
    for (int k = 1; k <= max; k++) begin
      step();
      if (bus.expired === 1'b1) np++;
      if (bus.remaining == 4'(val)) begin
        cyc = k;
        break;
      end
    end
  endtask

  int first, np, cyc, ticks;
  logic [3:0] rem_at [0:30];
  logic       busy_at [0:30];

  initial begin
    bus.start_timer = 1'b0;
    bus.interval_address = 2'b00;
    bus.prg_sync_in = 1'b0;
    bus.time_parameter_selector = 2'b00;
    bus.time_value = 4'd0;

    // reset state
    repeat (3) step();
    chk("rst_busy", bus.busy, 0);
    chk("rst_exp", bus.expired, 0);
    chk("rst_rem", bus.remaining, 0);
    chk("rst_hz", bus.one_hz_enable, 0);
    #3 sys_reset = 1'b1;
    step();

    // prescaler runs in IDLE: 2 ticks per 8 cycles
    ticks = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (bus.one_hz_enable === 1'b1) ticks++;
    end
    chk("idle_ticks", ticks, 2);

    // scenario 1: base interval, 6 s -> 24 cycles
    pulse_start(2'b00);
    chk("s1_busy0", bus.busy, 1);
    chk("s1_rem0", bus.remaining, 6);
    first = -1;
    np = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      rem_at[k] = bus.remaining;
      busy_at[k] = bus.busy;
      if (bus.expired === 1'b1) begin
        np++;
        if (first < 0) first = k;
      end
    end
    chk("s1_rem3", rem_at[3], 6);
    chk("s1_rem4", rem_at[4], 5);
    chk("s1_rem20", rem_at[20], 1);
    chk("s1_rem23", rem_at[23], 1);
    chk("s1_busy23", busy_at[23], 1);
    chk("s1_rem24", rem_at[24], 0);
    chk("s1_busy24", busy_at[24], 0);
    chk("s1_first", first, 24);
    chk("s1_pulses", np, 1);
    chk("s1_idle_rem", bus.remaining, 0);

    // scenario 2: extended = 9 -> 36 cycles, base still 6
    wr(2'b01, 4'd9);
    pulse_start(2'b01);
    chk("s2_rem0", bus.remaining, 9);
    run(40, first, np);
    chk("s2_first", first, 36);
    chk("s2_pulses", np, 1);
    pulse_start(2'b00);
    chk("s2_base", bus.remaining, 6);
    run(26, first, np);
    chk("s2_base_first", first, 24);

    // scenario 3: yellow written 0 keeps default 2 -> 8 cycles
    wr(2'b10, 4'd0);
    pulse_start(2'b10);
    chk("s3_rem0", bus.remaining, 2);
    run(12, first, np);
    chk("s3_first", first, 8);
    chk("s3_pulses", np, 1);

    // scenario 3b: address 11 aliases base
    pulse_start(2'b11);
    chk("s3_alias", bus.remaining, 6);

    // scenario 4: write aborts a running count
    pulse_start(2'b00);
    wait_rem(4, 20, cyc, np);
    chk("s4_cyc", cyc, 8);
    wr(2'b00, 4'd6);
    chk("s4_busy", bus.busy, 0);
    chk("s4_rem", bus.remaining, 0);
    run(30, first, np);
    chk("s4_pulses", np, 0);

    // scenario 5: re-start with yellow at remaining 3
    pulse_start(2'b00);
    wait_rem(3, 20, cyc, np);
    chk("s5_cyc", cyc, 12);
    chk("s5_pre_pulses", np, 0);
    pulse_start(2'b10);
    chk("s5_rem", bus.remaining, 2);
    chk("s5_busy", bus.busy, 1);
    run(30, first, np);
    chk("s5_first", first, 8);
    chk("s5_pulses", np, 1);

    // scenario 6: start and write together -> write wins
    bus.start_timer = 1'b1;
    bus.interval_address = 2'b00;
    wr(2'b00, 4'd5);
    bus.start_timer = 1'b0;
    chk("s6_busy", bus.busy, 0);
    chk("s6_rem", bus.remaining, 0);
    run(8, first, np);
    chk("s6_busy_late", bus.busy, 0);
    pulse_start(2'b00);
    chk("s6_base5", bus.remaining, 5);

    // asynchronous reset mid-count
    wait_rem(3, 20, cyc, np);
    chk("s6_cyc", cyc, 8);
    #3 sys_reset = 1'b0;
    #1;
    chk("ar_busy", bus.busy, 0);
    chk("ar_rem", bus.remaining, 0);
    chk("ar_exp", bus.expired, 0);
    chk("ar_hz", bus.one_hz_enable, 0);
    @(posedge clk);
    #3 sys_reset = 1'b1;
    step();
    pulse_start(2'b00);
    chk("ar_base", bus.remaining, 6);
    pulse_start(2'b01);
    chk("ar_ext", bus.remaining, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
